// File: rtl/muldiv_pkg.sv
// Shared operation codes and FSM state type for the E-stage multiply/divide unit.
package muldiv_pkg;
  localparam logic [2:0] mdu_MULT  = 3'd0;
  localparam logic [2:0] mdu_MULTU = 3'd1;
  localparam logic [2:0] mdu_DIV   = 3'd2;
  localparam logic [2:0] mdu_DIVU  = 3'd3;
  localparam logic [2:0] mdu_MTHI  = 3'd4;
  localparam logic [2:0] mdu_MTLO  = 3'd5;
  localparam logic [2:0] mdu_MADD  = 3'd6;
  localparam logic [2:0] mdu_MADDU = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL, DIV} mdu_state_t;
endpackage

// File: rtl/muldiv_calc.sv
// Combinational datapath: product, quotient/remainder or accumulate on latched operands.
// MADD/MADDU accumulation is present only when MDU_MADD_EN is defined.
module muldiv_calc
  import muldiv_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_res,
  output logic        o_dz
);
  logic        w_sgn, w_neg_a, w_neg_b, w_is_div, w_dz;
  logic [31:0] w_mag_a, w_mag_b, w_dvsr, w_q, w_r, w_q_s, w_r_s;
  logic [63:0] w_umag, w_prod;

  assign w_sgn   = (i_op == mdu_MULT) || (i_op == mdu_DIV) || (i_op == mdu_MADD);
  assign w_neg_a = w_sgn & i_a[31];
  assign w_neg_b = w_sgn & i_b[31];
  // Work on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
  assign w_mag_a = w_neg_a ? -i_a : i_a;
  assign w_mag_b = w_neg_b ? -i_b : i_b;

  assign w_umag = {32'd0, w_mag_a} * {32'd0, w_mag_b};
  assign w_prod = (w_neg_a ^ w_neg_b) ? -w_umag : w_umag;

  assign w_is_div = (i_op == mdu_DIV) || (i_op == mdu_DIVU);
  assign w_dz     = (i_b == 32'd0);
  assign w_dvsr   = w_dz ? 32'd1 : w_mag_b;
  assign w_q      = w_mag_a / w_dvsr;
  assign w_r      = w_mag_a % w_dvsr;
  assign w_q_s    = (w_neg_a ^ w_neg_b) ? -w_q : w_q;
  assign w_r_s    = w_neg_a ? -w_r : w_r;
  assign o_dz     = w_is_div & w_dz;

  always_comb begin
    o_res = {i_hi, i_lo};
    case (i_op)
      mdu_MULT, mdu_MULTU: o_res = w_prod;
      mdu_DIV, mdu_DIVU:   o_res = {w_r_s, w_q_s};
`ifdef MDU_MADD_EN
      mdu_MADD, mdu_MADDU: o_res = {i_hi, i_lo} + w_prod;
`endif
      default:             o_res = {i_hi, i_lo};
    endcase
  end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy drives the hazard stall.
// Optional MADD/MADDU (mod 6/7) enabled by defining MDU_MADD_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic        start,
  input  logic [2:0]  mod,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  mdu_state_t  r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [2:0]  r_op;
  logic        w_ld, w_commit, w_wr_hi, w_wr_lo, w_dz;
  logic [63:0] w_res;

  muldiv_calc u_calc (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .i_hi (r_hi),
    .i_lo (r_lo),
    .o_res(w_res),
    .o_dz (w_dz)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ld        = 1'b0;
    w_commit    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        case (mod)
`ifdef MDU_MADD_EN
          mdu_MULT, mdu_MULTU, mdu_MADD, mdu_MADDU: begin
`else
          mdu_MULT, mdu_MULTU: begin
`endif
            w_ld        = 1'b1;
            w_cnt_nxt   = CW'(MUL_LAT);
            w_state_nxt = MUL;
          end
          mdu_DIV, mdu_DIVU: begin
            w_ld        = 1'b1;
            w_cnt_nxt   = CW'(DIV_LAT);
            w_state_nxt = DIV;
          end
          mdu_MTHI: w_wr_hi = 1'b1;
          mdu_MTLO: w_wr_lo = 1'b1;
          default: ;
        endcase
      end
      MUL, DIV: begin
        // start is ignored here; the hazard unit never issues one while busy.
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = IDLE;
          w_commit    = !w_dz;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_ld) begin
        r_a  <= d1;
        r_b  <= d2;
        r_op <= mod;
      end
      if (w_commit) {r_hi, r_lo} <= w_res;
      if (w_wr_hi) r_hi <= d1;
      if (w_wr_lo) r_lo <= d1;
    end
  end

  assign HI   = r_hi;
  assign LO   = r_lo;
  assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency window, results, MTHI/MTLO, div-by-zero, reset abort.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d1, d2;
  logic        start;
  logic [2:0]  mod;
  logic [31:0] HI, LO;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] cur_hi, cur_lo;

  muldiv_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .rst(rst), .d1(d1), .d2(d2), .start(start), .mod(mod),
    .HI(HI), .LO(LO), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mod = m; d1 = a; d2 = b;
    step();
    start = 1'b0; mod = 3'd0;
    d1 = 32'hDEAD_BEEF; d2 = 32'h0BAD_F00D;
  endtask

  // Busy must hold for lat cycles with HI/LO unchanged, then drop with new values.
  task automatic run_op(input string tag, input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] nhi, input logic [31:0] nlo);
    issue(m, a, b);
    for (int i = 1; i <= lat; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_hold_hi"}, HI, cur_hi);
      chk({tag, "_hold_lo"}, LO, cur_lo);
      step();
    end
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, HI, nhi);
    chk({tag, "_lo"}, LO, nlo);
    cur_hi = nhi;
    cur_lo = nlo;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mod = 3'd0; d1 = '0; d2 = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    cur_hi = 32'h0; cur_lo = 32'h0;

    run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

    issue(3'd4, 32'h11, 32'h0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'h11);
    issue(3'd5, 32'h22, 32'h0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_lo", LO, 32'h22);
    chk("mtlo_hi_kept", HI, 32'h11);
    cur_hi = 32'h11; cur_lo = 32'h22;

    run_op("divz", 3'd2, 32'd100, 32'd0, 10, 32'h11, 32'h22);
    run_op("divuz", 3'd3, 32'd100, 32'd0, 10, 32'h11, 32'h22);

    // A start arriving mid-operation (here an MTHI) must not disturb anything.
    issue(3'd1, 32'd6, 32'd7);
    step();
    start = 1'b1; mod = 3'd4; d1 = 32'h5555_5555;
    step();
    start = 1'b0; mod = 3'd0;
    chk("ign_busy", {31'd0, busy}, 32'd1);
    chk("ign_hi", HI, 32'h11);
    step(); step(); step();
    chk("ign_done", {31'd0, busy}, 32'd0);
    chk("ign_res_hi", HI, 32'h0);
    chk("ign_res_lo", LO, 32'd42);

    // Reset at busy cycle 3 discards the in-flight MULT.
    issue(3'd0, 32'd9, 32'd9);
    step(); step();
    chk("rstmid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_hi", HI, 32'h0);
    chk("rstmid_lo", LO, 32'h0);
    chk("rstmid_busy0", {31'd0, busy}, 32'd0);
    step(); step(); step(); step();
    chk("rstmid_stay_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_stay_lo", LO, 32'h0);
    cur_hi = 32'h0; cur_lo = 32'h0;

    issue(3'd5, 32'hFFFF_FFFF, 32'h0);
    chk("pre_madd_lo", LO, 32'hFFFF_FFFF);
    cur_lo = 32'hFFFF_FFFF;
`ifdef MDU_MADD_EN
    run_op("maddu", 3'd7, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    run_op("madd",  3'd6, 32'hFFFF_FFFF, 32'd1, 5, 32'd0, 32'hFFFF_FFFF);
`else
    issue(3'd7, 32'd1, 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("maddu_off_busy", {31'd0, busy}, 32'd0);
      step();
    end
    chk("maddu_off_hi", HI, 32'h0);
    chk("maddu_off_lo", LO, 32'hFFFF_FFFF);
    issue(3'd6, 32'd3, 32'd3);
    chk("madd_off_busy", {31'd0, busy}, 32'd0);
    chk("madd_off_lo", LO, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
